// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A one-bit operand still needs a one-bit counter, hence the floor of 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : Single-bit combinational full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder reusing one full-adder cell, LSB first, with
//               valid/ready handshakes. Optional macro SERIAL_ADDER_OVERFLOW_EN
//               adds the signed-overflow output Ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_adder: WIDTH out of range");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shift;

    full_adder_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (c_q),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_s;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_s, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = rst_n && (state_q == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (cnt_q == CNT_LAST);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign Ovf       = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    c_d     = Cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = w_sum_shift;
                c_d      = w_co;
                cnt_d    = cnt_q + CW'(1);
                // Result registers only move on the final bit so Sum/Cout keep
                // the previous result while a new operation is in flight.
                if (w_last) begin
                    sum_d   = w_sum_shift;
                    cout_d  = w_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    ovf_d   = c_q ^ w_co;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Randomised and directed bench for serial_adder (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W      = 4;
    localparam int BUDGET = 4 * W + 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         Cin       = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         Ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned addition, overflow bit is the carry-out.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int unsigned t;
        t = int'(a) + int'(b) + int'(cin);
        return (W+1)'(t);
    endfunction

    // Reference: signed overflow if the true signed sum leaves the W-bit range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        int sa;
        int sb;
        int t;
        sa = $signed(a);
        sb = $signed(b);
        t  = sa + sb + int'(cin);
        return (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
    endfunction

    // Presents one operation, then waits (bounded) for out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic rdy_out, output logic rdy_seen, output int lat);
        A         = a;
        B         = b;
        Cin       = cin;
        in_valid  = 1'b1;
        out_ready = rdy_out;
        rdy_seen  = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        Cin      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid_low: got %b want 0", out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b want v=0 s=0 c=0",
                     out_valid, Sum, Cout);
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        n_cmp++;
        if (Ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_ovf: got %b want 0", Ovf);
        end
`endif
    endtask

    task automatic test_basic;
        logic rdy;
        int   lat;
        run_op(4'b0101, 4'b0011, 1'b0, 1'b1, rdy, lat);
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++; $display("FAIL basic_in_ready: got %b want 1", rdy);
        end
        n_cmp++;
        if (lat !== W) begin
            n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, W);
        end
        n_cmp++;
        if (Sum !== 4'b1000 || Cout !== 1'b0) begin
            n_err++; $display("FAIL basic_result: got s=%b c=%b want s=1000 c=0", Sum, Cout);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_return_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        n_cmp++;
        if (Sum !== 4'b1000) begin
            n_err++; $display("FAIL basic_sum_held_idle: got %b want 1000", Sum);
        end
    endtask

    task automatic test_all_ones;
        logic rdy;
        int   lat;
        run_op(4'b1111, 4'b1111, 1'b1, 1'b1, rdy, lat);
        n_cmp++;
        if (Sum !== 4'b1111 || Cout !== 1'b1 || lat !== W) begin
            n_err++;
            $display("FAIL all_ones: got s=%b c=%b lat=%0d want s=1111 c=1 lat=%0d",
                     Sum, Cout, lat, W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive;
        logic         rdy;
        int           lat;
        logic [8:0]   v;
        logic [W:0]   exp;
        for (int i = 0; i < 512; i++) begin
            v   = 9'(i);
            exp = ref_add(v[8:5], v[4:1], v[0]);
            run_op(v[8:5], v[4:1], v[0], 1'b1, rdy, lat);
            n_cmp++;
            if ({Cout, Sum} !== exp || lat !== W || rdy !== 1'b1) begin
                n_err++;
                $display("FAIL exhaustive a=%h b=%h ci=%b: got %h lat=%0d rdy=%b want %h lat=%0d",
                         v[8:5], v[4:1], v[0], {Cout, Sum}, lat, rdy, exp, W);
            end
`ifdef SERIAL_ADDER_OVERFLOW_EN
            n_cmp++;
            if (Ovf !== ref_ovf(v[8:5], v[4:1], v[0])) begin
                n_err++;
                $display("FAIL exhaustive_ovf a=%h b=%h ci=%b: got %b want %b",
                         v[8:5], v[4:1], v[0], Ovf, ref_ovf(v[8:5], v[4:1], v[0]));
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic rdy;
        int   lat;
        run_op(4'b1001, 4'b0111, 1'b0, 1'b0, rdy, lat);
        n_cmp++;
        if (lat !== W || Sum !== 4'b0000 || Cout !== 1'b1) begin
            n_err++;
            $display("FAIL bp_result: got s=%b c=%b lat=%0d want s=0000 c=1 lat=%0d",
                     Sum, Cout, lat, W);
        end
        A        = 4'b0011;
        B        = 4'b0100;
        Cin      = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || Sum !== 4'b0000 || Cout !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got v=%b s=%b c=%b r=%b want v=1 s=0000 c=1 r=0",
                         k, out_valid, Sum, Cout, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        run_op(4'b0011, 4'b0100, 1'b1, 1'b1, rdy, lat);
        n_cmp++;
        if (lat !== W || Sum !== 4'b1000 || Cout !== 1'b0) begin
            n_err++;
            $display("FAIL bp_followup: got s=%b c=%b lat=%0d want s=1000 c=0 lat=%0d",
                     Sum, Cout, lat, W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_add;
        logic rdy;
        int   lat;
        logic seen_valid;
        A         = 4'b0110;
        B         = 4'b0001;
        Cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || Sum !== '0 || Cout !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v=%b s=%b c=%b r=%b want v=0 s=0000 c=0 r=0",
                     out_valid, Sum, Cout, in_ready);
        end
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_no_result: got seen_valid=%b r=%b want 0 and 1",
                     seen_valid, in_ready);
        end
        run_op(4'b0010, 4'b0010, 1'b0, 1'b1, rdy, lat);
        n_cmp++;
        if (lat !== W || Sum !== 4'b0100 || Cout !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_followup: got s=%b c=%b lat=%0d want s=0100 c=0 lat=%0d",
                     Sum, Cout, lat, W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic         rdy;
        int           lat;
        int           stall;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W:0]   exp;
        for (int n = 0; n < 60; n++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            ci    = 1'($urandom);
            stall = $urandom_range(0, 3);
            exp   = ref_add(a, b, ci);
            run_op(a, b, ci, (stall == 0), rdy, lat);
            n_cmp++;
            if ({Cout, Sum} !== exp || lat !== W) begin
                n_err++;
                $display("FAIL random a=%h b=%h ci=%b: got %h lat=%0d want %h lat=%0d",
                         a, b, ci, {Cout, Sum}, lat, exp, W);
            end
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                n_cmp++;
                if (out_valid !== 1'b1 || {Cout, Sum} !== exp) begin
                    n_err++;
                    $display("FAIL random_hold: got v=%b %h want v=1 %h", out_valid, {Cout, Sum}, exp);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL random_drain: got v=%b want 0", out_valid);
            end
        end
    endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
    task automatic test_ovf;
        logic rdy;
        int   lat;
        run_op(4'b0111, 4'b0001, 1'b0, 1'b1, rdy, lat);
        n_cmp++;
        if (Sum !== 4'b1000 || Cout !== 1'b0 || Ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_pos: got s=%b c=%b o=%b want s=1000 c=0 o=1", Sum, Cout, Ovf);
        end
        @(posedge clk); #1;
        run_op(4'b1111, 4'b0001, 1'b0, 1'b1, rdy, lat);
        n_cmp++;
        if (Sum !== 4'b0000 || Cout !== 1'b1 || Ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_neg: got s=%b c=%b o=%b want s=0000 c=1 o=0", Sum, Cout, Ovf);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_exhaustive();
        test_backpressure();
        test_reset_mid_add();
        test_random();
`ifdef SERIAL_ADDER_OVERFLOW_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
